// File: rtl/phase_chain_loader_pkg.sv
// Shared constants and FSM encoding for the phase chain loader.
// Imported by the loader top and its tick divider.
package phase_chain_loader_pkg;

  localparam int PH_W      = 4;
  localparam int STAGE_LEN = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/phase_chain_loader_tick_gen.sv
// Shift-strobe divider: tick is high for one clk out of TICK_DIV.
// Ports: clk, rst_n, clr (restart period), run (count enable), tick.
module phase_chain_loader_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] nxt;

  assign nxt = (cnt == LAST) ? '0 : cnt + CW'(1);

  // tick is registered: it is loaded with the decode of the
  // counter value the next cycle will hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!run) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= (LAST == '0);
    end else begin
      cnt  <= nxt;
      tick <= (nxt == LAST);
    end
  end

endmodule

// File: rtl/phase_chain_loader.sv
// Serialises N initial phases into the state_in chain and reads back
// the old contents. Ports: clk, rst_n, start, phases, ser_ret ->
// full_tick, ser_state_in, busy, done, rb_phases.
module phase_chain_loader
  import phase_chain_loader_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int TICK_DIV  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [PH_W*N_NEURONS-1:0] phases,
  input  logic                      ser_ret,
  output logic                      full_tick,
  output logic                      ser_state_in,
  output logic                      busy,
  output logic                      done,
  output logic [PH_W*N_NEURONS-1:0] rb_phases
);

  localparam int L  = STAGE_LEN * N_NEURONS;
  localparam int W  = PH_W * N_NEURONS;
  localparam int BW = (L > 1) ? $clog2(L) : 1;
  localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int AW = $clog2(W);

  state_t        state;
  logic [W-1:0]  shadow;
  logic [W-1:0]  rb_buf;
  logic [W-1:0]  rb_next;
  logic [BW-1:0] bit_idx;
  logic [2:0]    pos;
  logic [2:0]    pos_n;
  logic [NW-1:0] nrn;
  logic [NW-1:0] nrn_n;
  logic [AW-1:0] idx_c;
  logic [AW-1:0] idx_n;
  logic          ser_next;
  logic          accept;
  logic          last;
  logic          finish;
  logic          run;
  int            tmp_c;
  int            tmp_n;

  assign accept = (state == ST_IDLE) && start;
  assign last   = (bit_idx == BW'(L - 1));
  assign finish = (state == ST_SHIFT) && full_tick && last;
  assign run    = accept || ((state == ST_SHIFT) && !finish);

  phase_chain_loader_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .run  (run),
    .tick (full_tick)
  );

  // pos is the slot within a 5-bit neuron frame (0 = pad),
  // nrn the neuron being sent; slot p carries phase bit 4-p.
  always_comb begin
    pos_n    = (pos == 3'd4) ? 3'd0 : pos + 3'd1;
    nrn_n    = (pos == 3'd4) ? nrn - NW'(1) : nrn;
    tmp_c    = int'(nrn) * PH_W + PH_W - int'(pos);
    tmp_n    = int'(nrn_n) * PH_W + PH_W - int'(pos_n);
    idx_c    = (pos == 3'd0) ? '0 : tmp_c[AW-1:0];
    idx_n    = (pos_n == 3'd0) ? '0 : tmp_n[AW-1:0];
    ser_next = (pos_n != 3'd0) && shadow[idx_n];
    rb_next  = rb_buf;
    if (pos != 3'd0) begin
      rb_next[idx_c] = ser_ret;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      shadow       <= '0;
      rb_buf       <= '0;
      rb_phases    <= '0;
      bit_idx      <= '0;
      pos          <= '0;
      nrn          <= '0;
      ser_state_in <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_SHIFT;
            shadow       <= phases;
            busy         <= 1'b1;
            bit_idx      <= '0;
            pos          <= '0;
            nrn          <= NW'(N_NEURONS - 1);
            ser_state_in <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (full_tick) begin
            rb_buf <= rb_next;
            if (last) begin
              state        <= ST_DONE;
              busy         <= 1'b0;
              done         <= 1'b1;
              ser_state_in <= 1'b0;
              rb_phases    <= rb_next;
            end else begin
              bit_idx      <= bit_idx + BW'(1);
              pos          <= pos_n;
              nrn          <= nrn_n;
              ser_state_in <= ser_next;
            end
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          bit_idx <= '0;
          pos     <= '0;
          nrn     <= '0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_chain_loader.sv
// Bench for phase_chain_loader with bit-level chain models.
// Two instances: N=4/TICK_DIV=4 and N=1/TICK_DIV=1.
module tb_phase_chain_loader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  // instance A: N=4, TICK_DIV=4
  logic        start_a;
  logic [15:0] phases_a;
  logic        ser_ret_a;
  logic        full_tick_a;
  logic        ser_a;
  logic        busy_a;
  logic        done_a;
  logic [15:0] rb_a;
  logic [19:0] chain_a = 20'h5A3C9;

  // instance B: N=1, TICK_DIV=1
  logic        start_b;
  logic [3:0]  phases_b;
  logic        ser_ret_b;
  logic        full_tick_b;
  logic        ser_b;
  logic        busy_b;
  logic        done_b;
  logic [3:0]  rb_b;
  logic [4:0]  chain_b = 5'b10110;

  phase_chain_loader #(.N_NEURONS(4), .TICK_DIV(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .phases(phases_a), .ser_ret(ser_ret_a),
    .full_tick(full_tick_a), .ser_state_in(ser_a),
    .busy(busy_a), .done(done_a), .rb_phases(rb_a)
  );

  phase_chain_loader #(.N_NEURONS(1), .TICK_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .phases(phases_b), .ser_ret(ser_ret_b),
    .full_tick(full_tick_b), .ser_state_in(ser_b),
    .busy(busy_b), .done(done_b), .rb_phases(rb_b)
  );

  // Chain models: bit 0 nearest the chain input; each stage is
  // 5 flops, ini_phase bit i at offset i, out flop at offset 4.
  assign ser_ret_a = chain_a[19];
  assign ser_ret_b = chain_b[4];

  always @(posedge clk)
    if (full_tick_a) chain_a <= {chain_a[18:0], ser_a};

  always @(posedge clk)
    if (full_tick_b) chain_b <= {chain_b[3:0], ser_b};

  function automatic logic [15:0] ini_a(input logic [19:0] c);
    logic [15:0] v;
    for (int j = 0; j < 4; j++) v[4*j +: 4] = c[5*j +: 4];
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_a(input string tag, input logic [15:0] ph,
                        input bit poke, input logic [15:0] alt);
    logic [15:0] exp_rb;
    logic [19:0] exp_ser;
    logic [19:0] got_ser;
    logic [15:0] rb_done;
    int nt;
    int nd;
    int dcyc;
    bit space_ok;
    bit busy_done;
    exp_rb = ini_a(chain_a);
    exp_ser = '0;
    for (int n = 3; n >= 0; n--)
      exp_ser = {exp_ser[14:0], 1'b0, ph[4*n+3], ph[4*n+2],
                 ph[4*n+1], ph[4*n]};
    got_ser = '0;
    rb_done = '0;
    nt = 0;
    nd = 0;
    dcyc = 0;
    space_ok = 1'b1;
    busy_done = 1'b1;
    @(negedge clk);
    phases_a = ph;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int cyc = 1; cyc <= 92; cyc++) begin
      if (poke && cyc == 30) begin
        start_a = 1'b1;
        phases_a = alt;
      end
      if (poke && cyc == 31) start_a = 1'b0;
      if (full_tick_a) begin
        nt++;
        if (cyc != nt * 4) space_ok = 1'b0;
        got_ser = {got_ser[18:0], ser_a};
      end
      if (done_a) begin
        nd++;
        dcyc = cyc;
        rb_done = rb_a;
        busy_done = busy_a;
      end
      @(negedge clk);
    end
    check({tag, "_ticks"}, nt, 20);
    check({tag, "_spacing"}, space_ok, 1);
    check({tag, "_done_cyc"}, dcyc, 81);
    check({tag, "_done_cnt"}, nd, 1);
    check({tag, "_busy_at_done"}, busy_done, 0);
    check({tag, "_ser_seq"}, got_ser, exp_ser);
    check({tag, "_rb"}, rb_done, exp_rb);
    check({tag, "_chain"}, ini_a(chain_a), ph);
  endtask

  initial begin
    logic [15:0] ph;
    int nt;
    int ticks_idle;
    bit out_idle;
    logic [15:0] tmask;
    logic [4:0] bser;
    int bdone;

    rst_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    phases_a = '0;
    phases_b = '0;
    repeat (3) @(negedge clk);
    check("rst_outs_a", {busy_a, done_a, full_tick_a, ser_a, rb_a}, 0);
    check("rst_outs_b", {busy_b, done_b, full_tick_b, ser_b, rb_b}, 0);
    rst_n = 1'b1;

    ticks_idle = 0;
    out_idle = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (full_tick_a || full_tick_b) ticks_idle++;
      if (busy_a || done_a || ser_a || rb_a != 0) out_idle = 1'b0;
      if (busy_b || done_b || ser_b || rb_b != 0) out_idle = 1'b0;
    end
    check("idle_ticks", ticks_idle, 0);
    check("idle_outs", out_idle, 1);

    load_a("basic", 16'hA53C, 1'b0, 16'h0);
    check("basic_chain_const", ini_a(chain_a), 16'hA53C);
    load_a("readback", 16'h1234, 1'b0, 16'h0);
    check("readback_const", rb_a, 16'hA53C);

    ph = 16'($urandom);
    load_a("busy_start", ph, 1'b1, ~ph);

    for (int r = 0; r < 4; r++) begin
      ph = 16'($urandom);
      load_a($sformatf("rand%0d", r), ph, 1'b0, 16'h0);
    end

    // single-stage, divide-by-one instance
    tmask = '0;
    bser = '0;
    bdone = 0;
    @(negedge clk);
    phases_b = 4'h9;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (full_tick_b) begin
        tmask[cyc] = 1'b1;
        bser = {bser[3:0], ser_b};
      end
      if (done_b) bdone = cyc;
      @(negedge clk);
    end
    check("b_tick_cycles", tmask, 16'h003E);
    check("b_ser_seq", bser, 5'b01001);
    check("b_done_cyc", bdone, 6);
    check("b_chain", chain_b[3:0], 4'h9);

    // abort a load during its 7th tick with async reset
    @(negedge clk);
    phases_a = 16'($urandom);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    nt = 0;
    for (int cyc = 0; cyc < 200 && nt < 7; cyc++) begin
      if (full_tick_a) nt++;
      if (nt < 7) @(negedge clk);
    end
    check("abort_reached_tick7", nt, 7);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outs", {busy_a, done_a, full_tick_a, ser_a}, 0);
    check("abort_rb", rb_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ph = 16'($urandom);
    load_a("after_abort", ph, 1'b0, 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/phase_chain_loader.md
Name: phase_chain_loader

Overview:
- Upstream feeder for the daisy-chained neuron initial-phase shift registers (state_in stages).
- Takes a parallel word of N 4-bit initial phases, serialises it onto the chain input and generates the shared full_tick shift strobe.
- Captures the bits that fall out of the chain end, so the previous phase contents are read back during every load.

Parameters:
- N_NEURONS, 4: number of state_in stages in the chain (>=1).
- TICK_DIV, 4: clk cycles per full_tick (>=1; 1 means full_tick is asserted every cycle while shifting).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  load request; sampled only in IDLE.
- phases  in  4*N_NEURONS  initial phases; neuron j at [4j+3:4j], where neuron 0 is nearest the chain input.
- ser_ret  in  1  ser_state_out of the last chain stage.
- full_tick  out  1  shift strobe to all chain stages.
- ser_state_in  out  1  serial data to the first chain stage.
- busy  out  1  high while loading.
- done  out  1  one-cycle pulse when the load completes.
- rb_phases  out  4*N_NEURONS  previous chain contents, same layout as phases.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; full_tick=0, ser_state_in=0, busy=0, done=0, rb_phases=0, all counters=0. Chain flops have no reset, so their contents stay undefined until the first load.
- Chain model: each stage has 5 flops, p0..p3 plus the registered out flop, giving a total length L=5*N_NEURONS.
- Frame order: neurons are sent from N-1 down to 0. Each neuron frame is 5 bits: a pad 0 for its out flop, then phase[3], [2], [1], [0]. After L ticks, every stage's ini_phase equals its phases slice.
- FSM states: IDLE, SHIFT, DONE.
- IDLE -> SHIFT:
  - On a clk edge with start=1.
  - phases latched into a shadow register; later changes to phases are ignored.
  - busy=1 from the next cycle.
  - div_cnt=0, bit_idx=0.
- SHIFT behaviour:
  - ser_state_in = frame bit bit_idx, held stable for the whole tick period.
  - div_cnt counts 0..TICK_DIV-1. full_tick=1 exactly while div_cnt==TICK_DIV-1.
  - In a cycle with full_tick=1: ser_ret is sampled into readback bit bit_idx, then bit_idx increments.
- Readback mapping: sample k maps to the same chain position as frame bit k. Pad samples are discarded; the rest are stored to rb_phases slice j, MSB first.
- SHIFT -> DONE: on the edge ending the tick with bit_idx==L-1.
- DONE:
  - Lasts one cycle: done=1, busy=0, full_tick=0, and rb_phases updated (all bits committed together).
  - Then returns to IDLE.
- Load latency: start edge to done=1 is L*TICK_DIV+1 cycles.
- full_tick, ser_state_in and busy are registered outputs.
- start while busy or in DONE: ignored, not queued.
- start held high: a new load begins on the first IDLE cycle after DONE.
- rst_n asserted mid-load: the load aborts immediately and rb_phases clears. The chain is left partially shifted, and the next load fully rewrites it.

Decomposition:
- Shared package: PH_W=4 (phase width), STAGE_LEN=5 (flops per chain stage), FSM state enum.
- One natural sub-module: tick_gen, the TICK_DIV divider producing full_tick with a sync clear.
- Frame serialiser and readback deserialiser stay inline.

Test Plan:
- Reset/idle: rst_n=0 then release → all outputs 0 and no full_tick for 100 cycles with start=0.
- Basic load: N=4, TICK_DIV=4, phases=16'hA53C, bench chain of 4 state_in models, start pulse → exactly 20 full_tick pulses spaced 4 cycles apart. done at cycle 81; stage ini_phases = C,3,5,A (neurons 0..3).
- Readback: a second load with phases=16'h1234 after the above → rb_phases=16'hA53C at done; chain now holds 4,3,2,1.
- TICK_DIV=1, N=1: phases=4'h9 → full_tick high for 5 consecutive cycles; ser_state_in sequence 0,1,0,0,1; done 6 cycles after start.
- start during busy: a second start pulse mid-load → no restart, a single done pulse, result unchanged; phases changed mid-load have no effect.
- Async reset at tick 7 of a load → outputs 0 immediately (asynchronously). A subsequent full load gives correct chain contents and rb_phases matching the partially shifted prior state.
